// File: rtl/read_data_packer.sv
// Read-issue and beat packer: issues rden pulses, captures rising-edge read beats, packs LANES beats per word into a FWFT FIFO.
// Latency: a beat captured in cycle t is visible on out_valid at t+1 at the earliest (when it completes a word).
// Backpressure: out_valid/out_ready stream; reads are only issued while the FIFO has a free slot, so pushes never overflow.
//
// Ports:
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   sys_en                block enable; dropping it while busy aborts the burst and flushes the FIFO
//   start, burst_len      burst request; burst_len sampled on start
//   rden                  1-cycle read-issue pulse towards the read engine
//   rd_req_in/_data_in/_addr_in   read engine request (0->1 edge = one beat), data and address
//   out_valid/out_ready/out_data/out_addr/out_last   packed word stream (lane 0 in LSBs)
//   busy, done, err_timeout       status: burst active, completion pulse, sticky timeout
module read_data_packer #(
    parameter int DATA_W     = 9,
    parameter int ADDR_W     = 21,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      sys_en,
    input  logic                      start,
    input  logic [15:0]               burst_len,
    output logic                      rden,
    input  logic                      rd_req_in,
    input  logic [DATA_W-1:0]         rd_data_in,
    input  logic [ADDR_W-1:0]         rd_addr_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);

    localparam int WORD_W = LANES * DATA_W;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } word_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, FLUSH, DONE} state_t;

    state_t                          state;
    logic [15:0]                     len_q;
    logic [15:0]                     issued;
    logic [15:0]                     beats;
    logic [IDX_W-1:0]                idx;
    logic [LANES-1:0][DATA_W-1:0]    lane_q;
    logic [ADDR_W-1:0]               addr_q;
    logic [TMO_W-1:0]                tmo;
    logic                            req_q;

    word_t                           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                count;

    logic                            beat;
    logic                            idx_last;
    logic                            full;
    logic                            abort;
    logic                            push;
    logic                            pop;
    logic [15:0]                     beat_num;
    logic [LANES-1:0][DATA_W-1:0]    lane_next;
    word_t                           push_word;
    word_t                           head;

    // Only a 0->1 transition of the request counts, so a request held high is one beat.
    assign beat     = rd_req_in & ~req_q;
    assign idx_last = (idx == IDX_W'(LANES - 1));
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign abort    = ~sys_en & (state != IDLE);
    assign beat_num = beats + 16'd1;
    assign pop      = out_valid & out_ready;

    always_comb begin
        lane_next      = lane_q;
        lane_next[idx] = rd_data_in;
    end

    // Pushes are combinational so a completing beat lands in the FIFO on the same edge.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (sys_en) begin
            if (state == WAIT_DATA && beat && idx_last) begin
                push           = 1'b1;
                push_word.data = lane_next;
                push_word.addr = (idx == '0) ? rd_addr_in : addr_q;
                push_word.last = (beat_num == len_q);
            end else if (state == FLUSH && idx != '0) begin
                // Unused upper lanes are already zero: lanes are cleared after every full push.
                push           = 1'b1;
                push_word.data = lane_q;
                push_word.addr = addr_q;
                push_word.last = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= rd_req_in;
        end
    end

    // First-word-fall-through FIFO; abort empties it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = head.data;
    assign out_addr  = head.addr;
    assign out_last  = head.last;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rden        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            len_q       <= '0;
            issued      <= '0;
            beats       <= '0;
            idx         <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            tmo         <= '0;
        end else begin
            rden <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                lane_q <= '0;
                idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && sys_en) begin
                            len_q       <= burst_len;
                            err_timeout <= 1'b0;
                            issued      <= '0;
                            beats       <= '0;
                            idx         <= '0;
                            lane_q      <= '0;
                            if (burst_len == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                state <= ISSUE;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        // A free slot now guarantees room for the push this read may cause.
                        if (!full) begin
                            rden   <= 1'b1;
                            issued <= issued + 16'd1;
                            tmo    <= '0;
                            state  <= WAIT_DATA;
                        end
                    end
                    WAIT_DATA: begin
                        if (beat) begin
                            beats <= beat_num;
                            if (idx == '0) begin
                                addr_q <= rd_addr_in;
                            end
                            if (idx_last) begin
                                idx    <= '0;
                                lane_q <= '0;
                            end else begin
                                idx    <= idx + IDX_W'(1);
                                lane_q <= lane_next;
                            end
                            state <= (issued < len_q) ? ISSUE : FLUSH;
                        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            lane_q      <= '0;
                            idx         <= '0;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    FLUSH: begin
                        idx    <= '0;
                        lane_q <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_read_data_packer.sv
module tb_read_data_packer;

    localparam int DATA_W     = 9;
    localparam int ADDR_W     = 21;
    localparam int LANES      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;
    localparam int WORD_W     = LANES * DATA_W;

    logic                 sys_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sys_en = 1'b0;
    logic                 start = 1'b0;
    logic [15:0]          burst_len = '0;
    logic                 rden;
    logic                 rd_req_in = 1'b0;
    logic [DATA_W-1:0]    rd_data_in = '0;
    logic [ADDR_W-1:0]    rd_addr_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WORD_W-1:0]    out_data;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 err_timeout;

    int checks = 0;
    int errors = 0;

    read_data_packer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sys_en(sys_en), .start(start),
        .burst_len(burst_len), .rden(rden), .rd_req_in(rd_req_in),
        .rd_data_in(rd_data_in), .rd_addr_in(rd_addr_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sink and event monitor: samples on the falling edge, decides ready for the coming edge.
    int              rden_cnt = 0;
    int              done_cnt = 0;
    int              stall_viol = 0;
    int              sink_mode = 1;
    logic [63:0]     got_q[$];
    logic            prev_stall = 1'b0;
    logic [63:0]     prev_word = '0;

    initial begin : monitor
        logic [63:0] w;
        logic        r;
        forever begin
            @(negedge sys_clk);
            w = {6'd0, out_last, out_addr, out_data};
            if (rden === 1'b1) rden_cnt++;
            if (done === 1'b1) done_cnt++;
            if (prev_stall && out_valid && (w !== prev_word)) stall_viol++;
            case (sink_mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                default: r = ($urandom_range(0, 1) == 1);
            endcase
            out_ready = r;
            if (out_valid && r) got_q.push_back(w);
            prev_stall = out_valid && !r;
            prev_word  = w;
        end
    end

    // Read engine model: one request edge per rden pulse, random delay and hold.
    int               served = 0;
    int               resp_en = 1;
    int               hold_fix = 0;
    int               beat_idx = 0;
    logic             resp_busy = 1'b0;
    logic [ADDR_W-1:0] addr_base = '0;
    longint unsigned  bd[$];
    longint unsigned  ba[$];

    initial begin : responder
        forever begin
            tick();
            if (rden_cnt > served) begin
                served++;
                if (resp_en != 0) begin
                    resp_busy = 1'b1;
                    repeat ($urandom_range(0, 3)) tick();
                    rd_req_in  = 1'b1;
                    rd_data_in = DATA_W'($urandom);
                    rd_addr_in = addr_base + ADDR_W'(beat_idx);
                    bd.push_back(longint'(rd_data_in));
                    ba.push_back(longint'(rd_addr_in));
                    beat_idx++;
                    repeat ((hold_fix > 0) ? hold_fix : $urandom_range(1, 3)) tick();
                    rd_req_in = 1'b0;
                    resp_busy = 1'b0;
                end
            end
        end
    end

    task automatic prepare();
        int n = 0;
        while (resp_busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        bd.delete();
        ba.delete();
        got_q.delete();
        beat_idx = 0;
    endtask

    task automatic start_burst(input int len);
        burst_len = 16'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        sink_mode = 1;
        while (out_valid && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    // Reference: beat i goes to word i/LANES, lane i%LANES; word address is that of its first beat.
    task automatic check_words(input string tag, input int n);
        int              nw;
        longint unsigned d;
        logic [63:0]     exp;
        logic [63:0]     obs;
        nw = (n + LANES - 1) / LANES;
        chk({tag, "_beats"}, bd.size(), n);
        chk({tag, "_words"}, got_q.size(), nw);
        for (int w = 0; w < nw; w++) begin
            d = 0;
            for (int k = 0; k < LANES; k++) begin
                if (w * LANES + k < n && w * LANES + k < bd.size())
                    d += bd[w * LANES + k] * (64'd1 << (DATA_W * k));
            end
            if (w * LANES < ba.size())
                d += ba[w * LANES] * (64'd1 << WORD_W);
            if (w == nw - 1)
                d += 64'd1 << (WORD_W + ADDR_W);
            exp = d;
            obs = (w < got_q.size()) ? got_q[w] : 64'hDEAD_BEEF_DEAD_BEEF;
            chk($sformatf("%s_word%0d", tag, w), obs, exp);
        end
    endtask

    initial begin : main
        int r0;
        int d0;
        int n;
        int len;

        rst_n = 1'b0;
        sys_en = 1'b0;
        sink_mode = 1;
        repeat (3) tick();
        chk("rst_rden", rden, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        sys_en = 1'b1;
        tick();

        // Eight beats at 0x10.. with an always-ready sink
        prepare();
        addr_base = 21'h10;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(8);
        chk("t1_busy", busy, 1);
        wait_idle("t1", 600);
        drain("t1");
        chk("t1_rden", rden_cnt - r0, 8);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_timeout, 0);
        check_words("t1", 8);

        // Partial final word
        prepare();
        addr_base = 21'h200;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(6);
        wait_idle("t2", 600);
        drain("t2");
        chk("t2_rden", rden_cnt - r0, 6);
        chk("t2_done", done_cnt - d0, 1);
        check_words("t2", 6);

        // Requests held high for five cycles, bursty sink
        prepare();
        addr_base = 21'h1000;
        hold_fix = 5;
        sink_mode = 2;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(8);
        wait_idle("t4", 1000);
        drain("t4");
        hold_fix = 0;
        chk("t4_rden", rden_cnt - r0, 8);
        chk("t4_done", done_cnt - d0, 1);
        check_words("t4", 8);

        // Stalled sink: reads stop once the FIFO is full, then resume
        prepare();
        addr_base = 21'h3000;
        sink_mode = 0;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(32);
        repeat (400) tick();
        chk("t3_rden_stalled", rden_cnt - r0, 16);
        chk("t3_valid_stalled", out_valid, 1);
        chk("t3_busy_stalled", busy, 1);
        sink_mode = 2;
        wait_idle("t3", 3000);
        drain("t3");
        chk("t3_rden", rden_cnt - r0, 32);
        chk("t3_done", done_cnt - d0, 1);
        check_words("t3", 32);

        // Random bursts
        for (int i = 0; i < 6; i++) begin
            prepare();
            len = $urandom_range(1, 13);
            addr_base = ADDR_W'($urandom);
            sink_mode = 2;
            r0 = rden_cnt; d0 = done_cnt;
            start_burst(len);
            wait_idle($sformatf("rnd%0d", i), 2000);
            drain($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_rden", i), rden_cnt - r0, len);
            chk($sformatf("rnd%0d_done", i), done_cnt - d0, 1);
            check_words($sformatf("rnd%0d", i), len);
        end

        // No response: timeout
        resp_en = 0;
        prepare();
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(4);
        repeat (30) tick();
        chk("t5_err_early", err_timeout, 0);
        chk("t5_busy_early", busy, 1);
        wait_idle("t5", 200);
        chk("t5_err", err_timeout, 1);
        chk("t5_done", done_cnt - d0, 0);
        chk("t5_rden", rden_cnt - r0, 1);
        chk("t5_valid", out_valid, 0);
        resp_en = 1;
        prepare();
        addr_base = 21'h5000;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(4);
        chk("t5_err_cleared", err_timeout, 0);
        wait_idle("t5b", 600);
        drain("t5b");
        chk("t5b_done", done_cnt - d0, 1);
        check_words("t5b", 4);

        // Abort by dropping sys_en
        prepare();
        sink_mode = 0;
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(20);
        n = 0;
        while (rden_cnt - r0 < 6 && n < 300) begin
            tick();
            n++;
        end
        chk("t6_reached", (rden_cnt - r0 >= 6), 1);
        chk("t6_pre_valid", out_valid, 1);
        sys_en = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_valid", out_valid, 0);
        tick();
        chk("t6_done", done_cnt - d0, 0);
        chk("t6_err", err_timeout, 0);
        sys_en = 1'b1;
        sink_mode = 1;

        // Zero-length burst
        prepare();
        r0 = rden_cnt; d0 = done_cnt;
        start_burst(0);
        chk("len0_done_pulse", done, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_done_low", done, 0);
        repeat (5) tick();
        chk("len0_rden", rden_cnt - r0, 0);
        chk("len0_done_cnt", done_cnt - d0, 1);

        // Asynchronous reset mid-burst
        prepare();
        r0 = rden_cnt;
        start_burst(12);
        n = 0;
        while (rden_cnt - r0 < 5 && n < 300) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_rden", rden, 0);
        chk("arst_data", out_data, 0);

        chk("hold_stable", stall_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
